// File: rtl/grf_scoreboard.sv
// Register-file hazard scoreboard: tracks in-flight GRF writers, stalls decode on
// unresolved RAW hazards and selects the forwarding stage for each source.
module grf_scoreboard #(
  parameter int COMMIT_DIST = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic        issue_we,
  input  logic [4:0]  issue_rd,
  input  logic [1:0]  issue_tnew,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [1:0]  tuse_rs,
  input  logic [1:0]  tuse_rt,
  output logic        stall,
  output logic [1:0]  fwd_rs,
  output logic [1:0]  fwd_rt,
  output logic [31:0] stall_count
);

  localparam logic [1:0] COMMIT_LD = 2'(COMMIT_DIST);

  logic [1:0]  commit_cnt [32];
  logic [1:0]  ready_cnt  [32];
  logic [31:0] stall_cnt_q;
  logic        haz_rs;
  logic        haz_rt;
  logic        accepted;
  logic        load_en;

  function automatic logic [1:0] dec_sat(input logic [1:0] v);
    return (v == 2'd0) ? 2'd0 : v - 2'd1;
  endfunction

  function automatic logic [31:0] inc_sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Distance travelled since issue maps directly onto the E/M/W forwarding select.
  function automatic logic [1:0] fwd_sel(input logic [4:0] r, input logic [1:0] cc);
    if (r == 5'd0 || cc == 2'd0) return 2'd0;
    return 2'(COMMIT_DIST + 1 - int'(cc));
  endfunction

  // Hazards are judged only against already-registered state, so stall never loops
  // back through the issue path.
  always_comb begin
    haz_rs = 1'b0;
    haz_rt = 1'b0;
    if (rs != 5'd0 && tuse_rs != 2'd3 && commit_cnt[rs] != 2'd0 && ready_cnt[rs] > tuse_rs)
      haz_rs = 1'b1;
    if (rt != 5'd0 && tuse_rt != 2'd3 && commit_cnt[rt] != 2'd0 && ready_cnt[rt] > tuse_rt)
      haz_rt = 1'b1;
  end

  assign stall       = haz_rs | haz_rt;
  assign accepted    = issue_valid & ~stall;
  assign load_en     = accepted & issue_we & (issue_rd != 5'd0);
  assign fwd_rs      = fwd_sel(rs, commit_cnt[rs]);
  assign fwd_rt      = fwd_sel(rt, commit_cnt[rt]);
  assign stall_count = stall_cnt_q;

  // Entry 0 is never loaded, so it stays idle from reset onward.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        commit_cnt[i] <= 2'd0;
        ready_cnt[i]  <= 2'd0;
      end
      stall_cnt_q <= 32'd0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (load_en && issue_rd == 5'(i)) begin
          commit_cnt[i] <= COMMIT_LD;
          ready_cnt[i]  <= issue_tnew;
        end else begin
          commit_cnt[i] <= dec_sat(commit_cnt[i]);
          ready_cnt[i]  <= dec_sat(ready_cnt[i]);
        end
      end
      if (stall) stall_cnt_q <= inc_sat(stall_cnt_q);
    end
  end

endmodule

// File: tb/tb_grf_scoreboard.sv
// Directed bench for grf_scoreboard: hand-computed stall/forward/stall_count values
// checked with immediate assertions on the falling edge.
module tb_grf_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic        issue_we;
  logic [4:0]  issue_rd;
  logic [1:0]  issue_tnew;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [1:0]  tuse_rs;
  logic [1:0]  tuse_rt;
  logic        stall;
  logic [1:0]  fwd_rs;
  logic [1:0]  fwd_rt;
  logic [31:0] stall_count;

  int tests  = 0;
  int failed = 0;

  grf_scoreboard #(.COMMIT_DIST(3)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_rd(issue_rd), .issue_tnew(issue_tnew),
    .rs(rs), .rt(rt), .tuse_rs(tuse_rs), .tuse_rt(tuse_rt),
    .stall(stall), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic [4:0] rd, input logic [1:0] tnew,
                       input logic [4:0] s, input logic [1:0] ts, input logic [4:0] t, input logic [1:0] tt);
    issue_valid = v;  issue_we = we; issue_rd = rd; issue_tnew = tnew;
    rs = s; tuse_rs = ts; rt = t; tuse_rt = tt;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 2'd0, 5'd0, 2'd3, 5'd0, 2'd3);
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    next_cycle();
    next_cycle();
    reset = 1'b0;
    #1;
    chk("rst_stall", stall, 1'b0);
    chk("rst_fwd_rs", fwd_rs, 2'd0);
    chk("rst_fwd_rt", fwd_rt, 2'd0);
    chk("rst_count", stall_count, 32'd0);

    // Writer rd=8 tnew=2, reader rs=8 tuse=0: two stall cycles then W forward.
    next_cycle();
    drive(1'b1, 1'b1, 5'd8, 2'd2, 5'd0, 2'd3, 5'd0, 2'd3);
    chk("r8_issue_stall", stall, 1'b0);
    next_cycle();
    drive(1'b1, 1'b0, 5'd0, 2'd0, 5'd8, 2'd0, 5'd0, 2'd3);
    chk("r8_stall1", stall, 1'b1);
    next_cycle();
    #1;
    chk("r8_stall2", stall, 1'b1);
    chk("r8_count1", stall_count, 32'd1);
    next_cycle();
    #1;
    chk("r8_release", stall, 1'b0);
    chk("r8_fwd_w", fwd_rs, 2'd3);
    chk("r8_count2", stall_count, 32'd2);

    // Writer rd=9 tnew=0: reader on rt walks E, M, W, then GRF.
    next_cycle();
    drive(1'b1, 1'b1, 5'd9, 2'd0, 5'd0, 2'd3, 5'd0, 2'd3);
    next_cycle();
    drive(1'b1, 1'b0, 5'd0, 2'd0, 5'd0, 2'd3, 5'd9, 2'd0);
    chk("r9_stall", stall, 1'b0);
    chk("r9_fwd_e", fwd_rt, 2'd1);
    next_cycle(); #1;
    chk("r9_fwd_m", fwd_rt, 2'd2);
    next_cycle(); #1;
    chk("r9_fwd_w", fwd_rt, 2'd3);
    next_cycle(); #1;
    chk("r9_fwd_grf", fwd_rt, 2'd0);
    chk("r9_count", stall_count, 32'd2);

    // Register 0 is never tracked.
    next_cycle();
    drive(1'b1, 1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd3);
    next_cycle();
    drive(1'b1, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
    chk("r0_stall", stall, 1'b0);
    chk("r0_fwd", fwd_rs, 2'd0);

    // Back-to-back writers to rd=5: newest (tnew=0) wins.
    next_cycle();
    drive(1'b1, 1'b1, 5'd5, 2'd3, 5'd0, 2'd3, 5'd0, 2'd3);
    next_cycle();
    drive(1'b1, 1'b1, 5'd5, 2'd0, 5'd1, 2'd3, 5'd2, 2'd3);
    chk("r5_reissue_stall", stall, 1'b0);
    next_cycle();
    drive(1'b1, 1'b0, 5'd0, 2'd0, 5'd5, 2'd0, 5'd0, 2'd3);
    chk("r5_stall", stall, 1'b0);
    chk("r5_fwd_e", fwd_rs, 2'd1);
    next_cycle(); idle();
    next_cycle(); next_cycle(); next_cycle();

    // rt with tuse=3 never stalls; tuse=1 stalls while ready_cnt=2.
    drive(1'b1, 1'b1, 5'd10, 2'd3, 5'd0, 2'd3, 5'd0, 2'd3);
    next_cycle();
    drive(1'b1, 1'b0, 5'd0, 2'd0, 5'd0, 2'd3, 5'd10, 2'd3);
    chk("r10_unused_stall", stall, 1'b0);
    chk("r10_fwd_e", fwd_rt, 2'd1);
    next_cycle();
    drive(1'b1, 1'b0, 5'd0, 2'd0, 5'd0, 2'd3, 5'd10, 2'd1);
    chk("r10_tuse1_stall", stall, 1'b1);
    next_cycle(); #1;
    chk("r10_release", stall, 1'b0);
    chk("r10_fwd_w", fwd_rt, 2'd3);
    chk("r10_count", stall_count, 32'd3);
    next_cycle(); idle();
    next_cycle();

    // Reader of its own rd sees the older writer; its stalled issue is ignored.
    drive(1'b1, 1'b1, 5'd11, 2'd3, 5'd0, 2'd3, 5'd0, 2'd3);
    next_cycle();
    drive(1'b1, 1'b1, 5'd11, 2'd0, 5'd11, 2'd0, 5'd0, 2'd3);
    chk("r11_self_stall", stall, 1'b1);
    next_cycle(); next_cycle(); #1;
    chk("r11_stall3", stall, 1'b1);
    next_cycle(); #1;
    chk("r11_release", stall, 1'b0);
    chk("r11_fwd_grf", fwd_rs, 2'd0);
    chk("r11_count", stall_count, 32'd6);
    next_cycle(); idle();
    drive(1'b0, 1'b0, 5'd0, 2'd0, 5'd11, 2'd3, 5'd0, 2'd3);
    chk("r11_new_fwd_e", fwd_rs, 2'd1);

    // Reset mid-flight drops entries and discards a simultaneous issue.
    next_cycle(); next_cycle(); next_cycle();
    drive(1'b1, 1'b1, 5'd7, 2'd3, 5'd0, 2'd3, 5'd0, 2'd3);
    next_cycle();
    reset = 1'b1;
    drive(1'b1, 1'b1, 5'd12, 2'd3, 5'd0, 2'd3, 5'd0, 2'd3);
    next_cycle();
    reset = 1'b0;
    drive(1'b1, 1'b0, 5'd0, 2'd0, 5'd7, 2'd0, 5'd12, 2'd0);
    chk("rst7_stall", stall, 1'b0);
    chk("rst7_fwd_rs", fwd_rs, 2'd0);
    chk("rst12_fwd_rt", fwd_rt, 2'd0);
    chk("rst7_count", stall_count, 32'd0);

    // stall_count saturates at all-ones.
    next_cycle();
    drive(1'b1, 1'b1, 5'd13, 2'd3, 5'd0, 2'd3, 5'd0, 2'd3);
    next_cycle();
    drive(1'b1, 1'b0, 5'd0, 2'd0, 5'd13, 2'd0, 5'd0, 2'd3);
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    chk("sat_preload", stall_count, 32'hFFFF_FFFE);
    chk("sat_stall", stall, 1'b1);
    next_cycle(); #1;
    chk("sat_max", stall_count, 32'hFFFF_FFFF);
    chk("sat_stall2", stall, 1'b1);
    next_cycle(); #1;
    chk("sat_hold", stall_count, 32'hFFFF_FFFF);
    next_cycle(); idle();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
